// File: rtl/resp_tracker_if.sv
// resp_tracker_if: issue, response, writeback and status signals of the response tracker
interface resp_tracker_if #(
    parameter int TRANS_ID_BITS = 3,
    parameter int XLEN = 64
);
    logic flush_i;
    logic issue_valid_i;
    logic issue_ready_o;
    logic [TRANS_ID_BITS-1:0] issue_trans_id_i;
    logic [4:0] issue_rd_i;
    logic issue_xd_i;
    logic resp_valid_i;
    logic resp_ready_o;
    logic [4:0] resp_rd_i;
    logic [XLEN-1:0] resp_data_i;
    logic wb_valid_o;
    logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
    logic [XLEN-1:0] wb_result_o;
    logic busy_o;
    logic err_o;
    modport slave (
        input flush_i, issue_valid_i, issue_trans_id_i, issue_rd_i, issue_xd_i,
        input resp_valid_i, resp_rd_i, resp_data_i,
        output issue_ready_o, resp_ready_o, wb_valid_o, wb_trans_id_o, wb_result_o, busy_o, err_o
    );
    modport master (
        output flush_i, issue_valid_i, issue_trans_id_i, issue_rd_i, issue_xd_i,
        output resp_valid_i, resp_rd_i, resp_data_i,
        input issue_ready_o, resp_ready_o, wb_valid_o, wb_trans_id_o, wb_result_o, busy_o, err_o
    );
endinterface

// File: rtl/resp_tracker.sv
// resp_tracker: tracks outstanding accelerator commands and sequences their scoreboard writebacks
module resp_tracker #(
    parameter int DEPTH = 4,
    parameter int TRANS_ID_BITS = 3,
    parameter int XLEN = 64
) (
    input logic clk_i,
    input logic rst_ni,
    resp_tracker_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] xd_q;
    logic [TRANS_ID_BITS-1:0] id_q [DEPTH];
    logic [4:0] rd_q [DEPTH];
    logic [IW-1:0] free_idx;
    logic [IW-1:0] match_idx;
    logic [IW-1:0] ret_idx;
    logic free_any;
    logic hazard;
    logic match_hit;
    logic ret_hit;
    logic can_accept;
    logic accept;
    logic wb_valid_q;
    logic [TRANS_ID_BITS-1:0] wb_id_q;
    logic [XLEN-1:0] wb_result_q;
    logic err_q;
    // Scanning downward leaves the lowest matching index in each result
    always_comb begin
        free_idx = '0;
        match_idx = '0;
        ret_idx = '0;
        free_any = 1'b0;
        hazard = 1'b0;
        match_hit = 1'b0;
        ret_hit = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
            if (valid_q[i] && !xd_q[i]) begin
                ret_hit = 1'b1;
                ret_idx = IW'(i);
            end
            if (valid_q[i] && xd_q[i] && bus.resp_valid_i && rd_q[i] == bus.resp_rd_i) begin
                match_hit = 1'b1;
                match_idx = IW'(i);
            end
            if (valid_q[i] && xd_q[i] && bus.issue_xd_i && rd_q[i] == bus.issue_rd_i)
                hazard = 1'b1;
        end
    end
    assign can_accept = free_any && !bus.flush_i && !hazard;
    assign accept = bus.issue_valid_i && can_accept;
    assign bus.issue_ready_o = rst_ni && can_accept;
    assign bus.resp_ready_o = rst_ni;
    assign bus.busy_o = |valid_q;
    assign bus.wb_valid_o = wb_valid_q;
    assign bus.wb_trans_id_o = wb_id_q;
    assign bus.wb_result_o = wb_result_q;
    assign bus.err_o = err_q;
    // Freed and newly filled slots never coincide: one is valid, the other free
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            xd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i] <= '0;
                rd_q[i] <= '0;
            end
            wb_valid_q <= 1'b0;
            wb_id_q <= '0;
            wb_result_q <= '0;
            err_q <= 1'b0;
        end else if (bus.flush_i) begin
            valid_q <= '0;
            wb_valid_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            wb_valid_q <= match_hit || ret_hit;
            err_q <= bus.resp_valid_i && !match_hit;
            if (match_hit) begin
                valid_q[match_idx] <= 1'b0;
                wb_id_q <= id_q[match_idx];
                wb_result_q <= bus.resp_data_i;
            end else if (ret_hit) begin
                valid_q[ret_idx] <= 1'b0;
                wb_id_q <= id_q[ret_idx];
                wb_result_q <= '0;
            end
            if (accept) begin
                valid_q[free_idx] <= 1'b1;
                xd_q[free_idx] <= bus.issue_xd_i;
                id_q[free_idx] <= bus.issue_trans_id_i;
                rd_q[free_idx] <= bus.issue_rd_i;
            end
        end
    end
endmodule

// File: tb/tb_resp_tracker.sv
// tb_resp_tracker: directed scenarios plus randomized traffic against a slot-level reference model
module tb_resp_tracker;
    localparam int DEPTH = 4;
    localparam int TB = 3;
    localparam int XL = 64;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    resp_tracker_if #(.TRANS_ID_BITS(TB), .XLEN(XL)) bus();
    resp_tracker #(.DEPTH(DEPTH), .TRANS_ID_BITS(TB), .XLEN(XL)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .bus(bus)
    );
    bit mv[DEPTH];
    bit mxd[DEPTH];
    logic [TB-1:0] mid[DEPTH];
    logic [4:0] mrd[DEPTH];
    bit mwbv;
    bit merr;
    logic [TB-1:0] mwbid;
    logic [XL-1:0] mwbres;
    function automatic bit m_ready();
        bit free = 0;
        bit haz = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!mv[i]) free = 1;
            if (mv[i] && mxd[i] && bus.issue_xd_i && mrd[i] == bus.issue_rd_i) haz = 1;
        end
        return rst_n && free && !bus.flush_i && !haz;
    endfunction
    function automatic bit m_busy();
        bit b = 0;
        for (int i = 0; i < DEPTH; i++) b |= mv[i];
        return b;
    endfunction
    task automatic m_clear();
        for (int i = 0; i < DEPTH; i++) mv[i] = 0;
        mwbv = 0;
        merr = 0;
        mwbid = '0;
        mwbres = '0;
    endtask
    task automatic m_edge();
        bit acc;
        int hit = -1;
        int ret = -1;
        int fr = -1;
        acc = bus.issue_valid_i && m_ready();
        if (bus.flush_i) begin
            for (int i = 0; i < DEPTH; i++) mv[i] = 0;
            mwbv = 0;
            merr = 0;
            return;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (fr < 0 && !mv[i]) fr = i;
            if (ret < 0 && mv[i] && !mxd[i]) ret = i;
            if (hit < 0 && mv[i] && mxd[i] && bus.resp_valid_i && mrd[i] == bus.resp_rd_i) hit = i;
        end
        mwbv = (hit >= 0) || (ret >= 0);
        merr = bus.resp_valid_i && hit < 0;
        if (hit >= 0) begin
            mwbid = mid[hit];
            mwbres = bus.resp_data_i;
            mv[hit] = 0;
        end else if (ret >= 0) begin
            mwbid = mid[ret];
            mwbres = '0;
            mv[ret] = 0;
        end
        if (acc) begin
            mv[fr] = 1;
            mxd[fr] = bus.issue_xd_i;
            mid[fr] = bus.issue_trans_id_i;
            mrd[fr] = bus.issue_rd_i;
        end
    endtask
    task automatic idle();
        bus.flush_i = 0;
        bus.issue_valid_i = 0;
        bus.issue_trans_id_i = '0;
        bus.issue_rd_i = '0;
        bus.issue_xd_i = 0;
        bus.resp_valid_i = 0;
        bus.resp_rd_i = '0;
        bus.resp_data_i = '0;
    endtask
    task automatic tick();
        m_edge();
        @(negedge clk);
        idle();
    endtask
    task automatic issue(input logic [TB-1:0] id, input logic [4:0] rd, input bit xd);
        bus.issue_valid_i = 1;
        bus.issue_trans_id_i = id;
        bus.issue_rd_i = rd;
        bus.issue_xd_i = xd;
    endtask
    task automatic resp(input logic [4:0] rd, input logic [XL-1:0] d);
        bus.resp_valid_i = 1;
        bus.resp_rd_i = rd;
        bus.resp_data_i = d;
    endtask
    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 0;
        m_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask
    task automatic test_reset();
        @(negedge clk);
        idle();
        rst_n = 0;
        m_clear();
        #1;
        checks++;
        if ({bus.wb_valid_o, bus.err_o, bus.busy_o, bus.issue_ready_o, bus.resp_ready_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000", {bus.wb_valid_o, bus.err_o, bus.busy_o, bus.issue_ready_o, bus.resp_ready_o});
        end
        checks++;
        if (bus.wb_trans_id_o !== '0 || bus.wb_result_o !== '0) begin
            failures++;
            $display("FAIL reset_wb got id=%0d res=%h want 0", bus.wb_trans_id_o, bus.wb_result_o);
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++;
        if (bus.resp_ready_o !== 1'b1 || bus.issue_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL release_ready got resp=%b issue=%b want 1 1", bus.resp_ready_o, bus.issue_ready_o);
        end
    endtask
    task automatic test_basic();
        do_reset();
        issue(3'd2, 5'd5, 1);
        tick();
        tick();
        tick();
        resp(5'd5, 64'hDEAD);
        tick();
        checks++;
        if (bus.wb_valid_o !== 1'b1 || bus.wb_trans_id_o !== 3'd2 || bus.wb_result_o !== 64'hDEAD) begin
            failures++;
            $display("FAIL basic_wb got v=%b id=%0d res=%h want v=1 id=2 res=dead", bus.wb_valid_o, bus.wb_trans_id_o, bus.wb_result_o);
        end
        checks++;
        if (bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy got=%b want=0", bus.busy_o);
        end
        tick();
        checks++;
        if (bus.wb_valid_o !== 1'b0 || bus.wb_result_o !== 64'hDEAD) begin
            failures++;
            $display("FAIL basic_hold got v=%b res=%h want v=0 res=dead", bus.wb_valid_o, bus.wb_result_o);
        end
    endtask
    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(TB'(i), 5'(i + 1), 1);
            tick();
        end
        checks++;
        if (bus.issue_ready_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL full_ready got ready=%b busy=%b want 0 1", bus.issue_ready_o, bus.busy_o);
        end
        resp(5'd3, 64'h33);
        #1;
        checks++;
        if (bus.issue_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL full_same_cycle got ready=%b want 0", bus.issue_ready_o);
        end
        tick();
        checks++;
        if (bus.wb_valid_o !== 1'b1 || bus.wb_trans_id_o !== 3'd2 || bus.issue_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL full_free got v=%b id=%0d ready=%b want 1 2 1", bus.wb_valid_o, bus.wb_trans_id_o, bus.issue_ready_o);
        end
    endtask
    task automatic test_priority();
        do_reset();
        issue(3'd4, 5'd7, 1);
        tick();
        issue(3'd1, 5'd0, 0);
        resp(5'd7, 64'h77);
        tick();
        checks++;
        if (bus.wb_valid_o !== 1'b1 || bus.wb_trans_id_o !== 3'd4 || bus.wb_result_o !== 64'h77) begin
            failures++;
            $display("FAIL prio_first got v=%b id=%0d res=%h want 1 4 77", bus.wb_valid_o, bus.wb_trans_id_o, bus.wb_result_o);
        end
        tick();
        checks++;
        if (bus.wb_valid_o !== 1'b1 || bus.wb_trans_id_o !== 3'd1 || bus.wb_result_o !== 64'h0) begin
            failures++;
            $display("FAIL prio_second got v=%b id=%0d res=%h want 1 1 0", bus.wb_valid_o, bus.wb_trans_id_o, bus.wb_result_o);
        end
        tick();
        checks++;
        if (bus.wb_valid_o !== 1'b0 || bus.wb_trans_id_o !== 3'd1 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL prio_idle got v=%b id=%0d busy=%b want 0 1 0", bus.wb_valid_o, bus.wb_trans_id_o, bus.busy_o);
        end
    endtask
    task automatic test_hazard();
        do_reset();
        issue(3'd3, 5'd9, 1);
        tick();
        issue(3'd5, 5'd9, 1);
        #1;
        checks++;
        if (bus.issue_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL hazard_block got=%b want=0", bus.issue_ready_o);
        end
        bus.issue_valid_i = 0;
        bus.issue_xd_i = 0;
        #1;
        checks++;
        if (bus.issue_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL hazard_xd0 got=%b want=1", bus.issue_ready_o);
        end
        idle();
        resp(5'd12, 64'h1234);
        tick();
        checks++;
        if (bus.err_o !== 1'b1 || bus.wb_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL unmatched got err=%b wb=%b want 1 0", bus.err_o, bus.wb_valid_o);
        end
        tick();
        checks++;
        if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL err_pulse got err=%b busy=%b want 0 1", bus.err_o, bus.busy_o);
        end
    endtask
    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue(TB'(i), 5'(i + 1), 1);
            tick();
        end
        bus.flush_i = 1;
        issue(3'd6, 5'd20, 0);
        resp(5'd2, 64'h22);
        #1;
        checks++;
        if (bus.issue_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready got=%b want=0", bus.issue_ready_o);
        end
        tick();
        checks++;
        if (bus.busy_o !== 1'b0 || bus.wb_valid_o !== 1'b0 || bus.err_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_out got busy=%b wb=%b err=%b want 0 0 0", bus.busy_o, bus.wb_valid_o, bus.err_o);
        end
        tick();
        checks++;
        if (bus.busy_o !== 1'b0 || bus.wb_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_discard got busy=%b wb=%b want 0 0", bus.busy_o, bus.wb_valid_o);
        end
    endtask
    task automatic test_async_reset();
        do_reset();
        issue(3'd5, 5'd1, 1);
        tick();
        resp(5'd1, 64'hABC);
        issue(3'd6, 5'd2, 1);
        tick();
        issue(3'd7, 5'd3, 1);
        tick();
        checks++;
        if (bus.busy_o !== 1'b1 || bus.wb_trans_id_o !== 3'd5) begin
            failures++;
            $display("FAIL async_pre got busy=%b id=%0d want 1 5", bus.busy_o, bus.wb_trans_id_o);
        end
        #2;
        rst_n = 0;
        m_clear();
        #1;
        checks++;
        if ({bus.wb_valid_o, bus.err_o, bus.busy_o, bus.issue_ready_o, bus.resp_ready_o} !== 5'b0
            || bus.wb_trans_id_o !== '0 || bus.wb_result_o !== '0) begin
            failures++;
            $display("FAIL async_reset got flags=%b id=%0d res=%h want all 0",
                     {bus.wb_valid_o, bus.err_o, bus.busy_o, bus.issue_ready_o, bus.resp_ready_o}, bus.wb_trans_id_o, bus.wb_result_o);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.wb_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL async_after got busy=%b wb=%b want 0 0", bus.busy_o, bus.wb_valid_o);
        end
    endtask
    task automatic test_random();
        int k;
        logic [4:0] rr;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            idle();
            bus.flush_i = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1) issue(TB'($urandom), 5'($urandom_range(0, 7)), $urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, DEPTH - 1);
                rr = (mv[k] && mxd[k] && $urandom_range(0, 3) != 0) ? mrd[k] : 5'($urandom_range(0, 15));
                resp(rr, {$urandom, $urandom});
            end
            #1;
            checks++;
            if (bus.issue_ready_o !== m_ready() || bus.busy_o !== m_busy()) begin
                failures++;
                $display("FAIL rand_comb c=%0d got ready=%b busy=%b want %b %b", c, bus.issue_ready_o, bus.busy_o, m_ready(), m_busy());
            end
            tick();
            checks++;
            if (bus.wb_valid_o !== mwbv || bus.err_o !== merr || bus.wb_trans_id_o !== mwbid || bus.wb_result_o !== mwbres) begin
                failures++;
                $display("FAIL rand_reg c=%0d got v=%b err=%b id=%0d res=%h want v=%b err=%b id=%0d res=%h",
                         c, bus.wb_valid_o, bus.err_o, bus.wb_trans_id_o, bus.wb_result_o, mwbv, merr, mwbid, mwbres);
            end
        end
    endtask
    initial begin
        idle();
        m_clear();
        test_reset();
        test_basic();
        test_full();
        test_priority();
        test_hazard();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
